// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO and a valid/ready producer interface.
// Frames are start, DATA_W bits LSB-first, optional parity, then 1 or 2 stop bits, paced by baud_tick.
module uart_tx_fifo #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              par_en,
    input  logic              par_odd,
    input  logic              stop2,
    output logic              tx,
    output logic              tx_busy,
    output logic [FIFO_AW:0]  fifo_count,
    output logic              fifo_empty
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               push;
    logic               pop;
    logic [DATA_W-1:0]  head;

    state_t             state_q;
    state_t             state_d;
    logic               tx_q;
    logic               tx_d;
    logic               busy_q;
    logic               busy_d;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  shift_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               par_en_q;
    logic               par_en_d;
    logic               par_bit_q;
    logic               par_bit_d;
    logic               stop2_q;
    logic               stop2_d;
    logic               load_frame;
    logic               end_frame;

    assign s_ready    = (count_q != FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign fifo_count = count_q;
    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign push       = s_valid && s_ready;
    assign head       = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        load_frame = 1'b0;
        end_frame  = 1'b0;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (baud_tick && !fifo_empty) begin
                    load_frame = 1'b1;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = CNT_W'(1);
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (cnt_q < LAST_CNT) begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + 1'b1;
                    end else if (par_en_q) begin
                        tx_d    = par_bit_q;
                        state_d = S_PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_STOP1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (baud_tick) begin
                    if (stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        end_frame = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (baud_tick) begin
                    end_frame = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // A queued word at the closing stop tick starts the next frame with no idle gap.
        if (end_frame) begin
            if (fifo_empty) begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end else begin
                load_frame = 1'b1;
            end
        end

        if (load_frame) begin
            pop       = 1'b1;
            shift_d   = head;
            par_en_d  = par_en;
            par_bit_d = (^head) ^ par_odd;
            stop2_d   = stop2;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            state_d   = S_START;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based frame model checked every cycle, plus literal frame expectations.
module tb_uart_tx_fifo;

    localparam int DATA_W  = 8;
    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              baud_tick = 1'b0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              par_en = 1'b0;
    logic              par_odd = 1'b0;
    logic              stop2 = 1'b0;
    logic              s_ready;
    logic              tx;
    logic              tx_busy;
    logic [FIFO_AW:0]  fifo_count;
    logic              fifo_empty;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] src_q[$];
    int   gap_pct = 0;
    int   tick_mode = 0;
    int   tick_div = 4;
    int   tick_cnt = 0;
    logic last_tick = 1'b0;

    logic [DATA_W-1:0] m_q[$];
    bit                m_bits[$];
    logic              m_tx = 1'b1;
    logic              m_busy = 1'b0;

    uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .par_en     (par_en),
        .par_odd    (par_odd),
        .stop2      (stop2),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .fifo_empty (fifo_empty)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue plus the list of line bits still to be shown for the current frame.
    initial begin : model
        int pre;
        logic [DATA_W-1:0] w;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                m_bits.delete();
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end else begin
                pre = m_q.size();
                if (baud_tick) begin
                    if (m_bits.size() > 0) begin
                        m_tx = m_bits.pop_front();
                    end else if (pre > 0) begin
                        w = m_q.pop_front();
                        m_bits.push_back(1'b0);
                        for (int i = 0; i < DATA_W; i++) m_bits.push_back(w[i]);
                        if (par_en) m_bits.push_back((^w) ^ par_odd);
                        m_bits.push_back(1'b1);
                        if (stop2) m_bits.push_back(1'b1);
                        m_tx   = m_bits.pop_front();
                        m_busy = 1'b1;
                    end else begin
                        m_tx   = 1'b1;
                        m_busy = 1'b0;
                    end
                end
                if (s_valid && pre < DEPTH) m_q.push_back(s_data);
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("tx", tx, m_tx);
            chk("tx_busy", tx_busy, m_busy);
            chk("fifo_count", fifo_count, m_q.size());
            chk("fifo_empty", fifo_empty, m_q.size() == 0);
            chk("s_ready", s_ready, m_q.size() < DEPTH);
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: inputs set before the call are applied at the edge; returns at the following negedge.
    task automatic cyc();
        logic acc;
        logic lt;
        acc = s_valid && s_ready;
        lt  = baud_tick;
        @(posedge clk);
        @(negedge clk);
        last_tick = lt;
        if (acc && src_q.size() > 0) src_q.delete(0);
        if (src_q.size() > 0) begin
            if (!s_valid || acc) s_valid = ($urandom_range(0, 99) >= gap_pct);
        end else begin
            s_valid = 1'b0;
        end
        s_data = s_valid ? src_q[0] : DATA_W'($urandom);
        case (tick_mode)
            0: baud_tick = 1'b0;
            1: begin
                tick_cnt++;
                if (tick_cnt >= tick_div) begin
                    tick_cnt  = 0;
                    baud_tick = 1'b1;
                end else begin
                    baud_tick = 1'b0;
                end
            end
            default: baud_tick = ($urandom_range(0, 3) == 0);
        endcase
    endtask

    task automatic ticks_off();
        tick_mode = 0;
        baud_tick = 1'b0;
    endtask

    task automatic ticks_on(input int div);
        tick_mode = 1;
        tick_div  = div;
        tick_cnt  = 0;
        baud_tick = 1'b0;
    endtask

    task automatic settle();
        int g;
        g = 0;
        while ((src_q.size() > 0 || s_valid) && g < 200) begin
            cyc();
            g++;
        end
        if (g >= 200) chk("settle_timeout", g, 0);
        cyc();
    endtask

    task automatic capture(input int n, output logic [63:0] bits, output logic busy_all);
        int k;
        int g;
        k = 0;
        g = 0;
        bits = '0;
        busy_all = 1'b1;
        while (k < n && g < 4000) begin
            cyc();
            g++;
            if (last_tick) begin
                bits = {bits[62:0], tx};
                busy_all = busy_all & tx_busy;
                k++;
            end
        end
        if (k < n) chk("capture_timeout", k, n);
    endtask

    task automatic drain();
        int g;
        g = 0;
        gap_pct = 0;
        ticks_on(1);
        while ((src_q.size() > 0 || s_valid || m_q.size() > 0 || m_busy) && g < 5000) begin
            cyc();
            g++;
        end
        if (g >= 5000) chk("drain_timeout", g, 0);
        ticks_off();
    endtask

    initial begin : driver
        logic [63:0] b1;
        logic [63:0] b2;
        logic        bz1;
        logic        bz2;

        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_ready", s_ready, 1);
        rst = 1'b0;
        cyc();

        // 8N1, 0xA5, tick every 16 clocks
        {par_en, par_odd, stop2} = 3'b000;
        src_q.push_back(8'hA5);
        settle();
        chk("a5_count_before", fifo_count, 1);
        ticks_on(16);
        capture(1, b1, bz1);
        chk("a5_count_after_start", fifo_count, 0);
        capture(9, b2, bz2);
        chk("a5_bits", {b1[0], b2[8:0]}, 10'b0101001011);
        chk("a5_busy", bz1 & bz2, 1);
        capture(1, b1, bz1);
        chk("a5_idle_tx", tx, 1);
        chk("a5_idle_busy", tx_busy, 0);
        ticks_off();

        // even parity on 0x07; par_odd flipped mid-frame must be ignored
        {par_en, par_odd, stop2} = 3'b100;
        src_q.push_back(8'h07);
        settle();
        ticks_on(4);
        capture(5, b1, bz1);
        par_odd = 1'b1;
        capture(6, b2, bz2);
        chk("par_even_bits", {b1[4:0], b2[5:0]}, 11'b01110000011);
        chk("par_even_busy", bz1 & bz2, 1);
        capture(1, b1, bz1);
        chk("par_even_end_busy", tx_busy, 0);
        ticks_off();

        src_q.push_back(8'h07);
        settle();
        ticks_on(4);
        capture(11, b1, bz1);
        chk("par_odd_bits", b1[10:0], 11'b01110000001);
        capture(1, b2, bz2);
        chk("par_odd_end_busy", tx_busy, 0);
        ticks_off();

        // two stop bits on 0x00
        {par_en, par_odd, stop2} = 3'b001;
        src_q.push_back(8'h00);
        settle();
        ticks_on(3);
        capture(11, b1, bz1);
        chk("stop2_bits", b1[10:0], 11'b00000000011);
        chk("stop2_busy", bz1, 1);
        capture(1, b2, bz2);
        chk("stop2_end_tx", tx, 1);
        chk("stop2_end_busy", tx_busy, 0);
        ticks_off();

        // back-to-back frames
        {par_en, par_odd, stop2} = 3'b000;
        src_q.push_back(8'h11);
        src_q.push_back(8'h22);
        src_q.push_back(8'h33);
        settle();
        chk("b2b_count", fifo_count, 3);
        ticks_on(4);
        capture(30, b1, bz1);
        chk("b2b_bits", b1[29:0], 30'b0100010001_0010001001_0110011001);
        chk("b2b_busy", bz1, 1);
        capture(1, b2, bz2);
        chk("b2b_end_busy", tx_busy, 0);
        ticks_off();

        // full FIFO with the 17th word held off
        for (int i = 0; i < 17; i++) src_q.push_back(DATA_W'($urandom));
        repeat (30) cyc();
        chk("full_count", fifo_count, 16);
        chk("full_ready", s_ready, 0);
        chk("full_held", src_q.size(), 1);
        ticks_on(1);
        capture(1, b1, bz1);
        chk("full_pop_count", fifo_count, 15);
        cyc();
        chk("full_refill_count", fifo_count, 16);
        drain();

        // reset during data bit 3
        {par_en, par_odd, stop2} = 3'b000;
        src_q.push_back(8'h3C);
        src_q.push_back(8'h77);
        settle();
        ticks_on(4);
        capture(5, b1, bz1);
        chk("rst_mid_bits", b1[4:0], 5'b00011);
        #3;
        rst = 1'b1;
        src_q.delete();
        s_valid = 1'b0;
        ticks_off();
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_busy", tx_busy, 0);
        chk("async_rst_count", fifo_count, 0);
        chk("async_rst_empty", fifo_empty, 1);
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        src_q.push_back(8'h5A);
        settle();
        ticks_on(4);
        capture(10, b1, bz1);
        chk("post_rst_5a_bits", b1[9:0], 10'b0010110101);
        capture(1, b2, bz2);
        chk("post_rst_end_busy", tx_busy, 0);
        ticks_off();

        // randomized traffic, tick patterns and configuration changes
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                gap_pct = $urandom_range(0, 60);
                case ($urandom_range(0, 3))
                    0: ticks_on($urandom_range(1, 3));
                    1: ticks_on($urandom_range(4, 8));
                    2: tick_mode = 2;
                    default: ticks_off();
                endcase
            end
            if ($urandom_range(0, 49) == 0) {par_en, par_odd, stop2} = 3'($urandom);
            if (src_q.size() < 3 && $urandom_range(0, 2) == 0) src_q.push_back(DATA_W'($urandom));
            cyc();
        end
        drain();
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
